// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin, packet-locked arbiter sharing one FIFO push port
module fifo_push_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST = 16,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_push_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic [IDX_W-1:0]              fifo_id_o,
  output logic                          busy_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
  logic [0:0] state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, scan_idx, active;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic locked, any, go, xfer, end_burst;
  logic [DATA_WIDTH-1:0] data_sel;
  int scan_j;
  // Scan from rr_ptr_q downward in priority so the nearest valid requester is written last and wins
  always_comb begin
    scan_idx = rr_ptr_q;
    scan_j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_j = int'(rr_ptr_q) + k;
      scan_j = (scan_j >= NUM_REQ) ? scan_j - NUM_REQ : scan_j;
      scan_idx = req_valid_i[IDX_W'(scan_j)] ? IDX_W'(scan_j) : scan_idx;
    end
  end
  assign locked = state_q == LOCKED;
  assign active = locked ? owner_q : scan_idx;
  assign any = locked | (|req_valid_i);
  assign go = any & ~fifo_full_i & ~flush_i & ~rst_i;
  assign xfer = go & req_valid_i[active];
  assign end_burst = req_last_i[active] | ((MAX_BURST != 0) & (beat_cnt_q == LAST_CNT));
  // Route the active requester's beat to the FIFO and grant ready only to it
  always_comb begin
    data_sel = '0;
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      data_sel = (active == IDX_W'(i)) ? req_data_i[i*DATA_WIDTH +: DATA_WIDTH] : data_sel;
      req_ready_o[i] = go & (active == IDX_W'(i));
    end
  end
  assign fifo_push_o = xfer;
  assign fifo_data_o = rst_i ? '0 : data_sel;
  assign fifo_id_o = rst_i ? '0 : active;
  assign busy_o = locked & ~rst_i;
  // Flush beats everything; a finished burst releases and advances the pointer; otherwise lock and count
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (flush_i) begin
      state_d = IDLE;
      rr_ptr_d = '0;
      beat_cnt_d = '0;
    end else if (xfer && end_burst) begin
      state_d = IDLE;
      beat_cnt_d = '0;
      rr_ptr_d = (active == LAST_IDX) ? '0 : active + 1'b1;
    end else if (xfer) begin
      state_d = LOCKED;
      owner_d = active;
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end
  // Arbiter state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_ptr_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
  a_push_not_full: assert property (@(posedge clk_i) disable iff (rst_i) fifo_push_o |-> !fifo_full_i);
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(req_ready_o));
  a_ready_owner: assert property (@(posedge clk_i) disable iff (rst_i) (locked && |req_ready_o) |-> req_ready_o[owner_q]);
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: vector table, corner sequences and random traffic against a queue-level model
module tb_fifo_push_arbiter;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  logic clk_i = 1'b0;
  logic rst_i, flush_i, fifo_full_i, fifo_push_o, busy_o;
  logic [N-1:0] req_valid_i, req_last_i, req_ready_o;
  logic [N*DW-1:0] req_data_i;
  logic [DW-1:0] fifo_data_o;
  logic [1:0] fifo_id_o;
  int checks = 0;
  int failures = 0;
  bit m_locked;
  int m_owner, m_ptr, m_cnt, m_act;
  logic e_push, e_busy;
  logic [1:0] e_id;
  logic [N-1:0] e_ready;
  logic [DW-1:0] e_data;
  typedef struct {
    logic [N-1:0] v, l;
    logic f, fl, push;
    logic [1:0] id;
    logic [N-1:0] rdy;
    logic busy;
  } vec_t;
  vec_t tbl[$];

  fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .fifo_full_i(fifo_full_i), .fifo_push_o(fifo_push_o),
    .fifo_data_o(fifo_data_o), .fifo_id_o(fifo_id_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_owner = 0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  // Who should be served this cycle, from the arbitration rules alone
  task automatic model_eval();
    int a = -1;
    if (m_locked) a = m_owner;
    else for (int k = 0; k < N; k++) if (a < 0 && ((req_valid_i >> ((m_ptr + k) % N)) & 1) != 0) a = (m_ptr + k) % N;
    m_act = a;
    e_busy = m_locked;
    e_ready = '0;
    e_push = 0;
    e_id = 0;
    e_data = 0;
    if (a >= 0 && !fifo_full_i && !flush_i) begin
      e_ready = N'(1) << a;
      e_push = ((req_valid_i >> a) & 1) != 0;
    end
    if (e_push) begin
      e_id = 2'(a);
      e_data = DW'(req_data_i >> (a * DW));
    end
  endtask

  task automatic model_step();
    if (flush_i) begin
      m_locked = 0;
      m_cnt = 0;
      m_ptr = 0;
    end else if (e_push) begin
      m_cnt++;
      if (((req_last_i >> m_act) & 1) != 0 || m_cnt == MB) begin
        m_locked = 0;
        m_cnt = 0;
        m_ptr = (m_act + 1) % N;
      end else begin
        m_locked = 1;
        m_owner = m_act;
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] v, l, input logic f, fl);
    req_valid_i = v;
    req_last_i = l;
    fifo_full_i = f;
    flush_i = fl;
    for (int i = 0; i < N; i++) req_data_i[i*DW +: DW] = $urandom;
    #1;
    model_eval();
    chk("m_push", fifo_push_o, e_push);
    chk("m_ready", req_ready_o, e_ready);
    chk("m_busy", busy_o, e_busy);
    if (e_push) begin
      chk("m_id", fifo_id_o, e_id);
      chk("m_data", fifo_data_o, e_data);
    end
  endtask

  task automatic advance();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic add(input logic [N-1:0] v, l, input logic f, fl, push, input logic [1:0] id, input logic [N-1:0] rdy, input logic busy);
    vec_t t;
    t.v = v; t.l = l; t.f = f; t.fl = fl; t.push = push; t.id = id; t.rdy = rdy; t.busy = busy;
    tbl.push_back(t);
  endtask

  initial begin
    // single-beat round robin
    add(4'hF, 4'hF, 0, 0, 1, 0, 4'h1, 0);
    add(4'hF, 4'hF, 0, 0, 1, 1, 4'h2, 0);
    add(4'hF, 4'hF, 0, 0, 1, 2, 4'h4, 0);
    add(4'hF, 4'hF, 0, 0, 1, 3, 4'h8, 0);
    add(4'hF, 4'hF, 0, 0, 1, 0, 4'h1, 0);
    // 3-beat packet from req1
    add(4'h7, 4'h5, 0, 0, 1, 1, 4'h2, 0);
    add(4'h7, 4'h5, 0, 0, 1, 1, 4'h2, 1);
    add(4'h7, 4'h7, 0, 0, 1, 1, 4'h2, 1);
    add(4'h5, 4'h5, 0, 0, 1, 2, 4'h4, 0);
    add(4'h1, 4'h1, 0, 0, 1, 0, 4'h1, 0);
    // 6-beat packet from req2, forced release after 4
    add(4'hC, 4'h8, 0, 0, 1, 2, 4'h4, 0);
    add(4'hC, 4'h8, 0, 0, 1, 2, 4'h4, 1);
    add(4'hC, 4'h8, 0, 0, 1, 2, 4'h4, 1);
    add(4'hC, 4'h8, 0, 0, 1, 2, 4'h4, 1);
    add(4'hC, 4'h8, 0, 0, 1, 3, 4'h8, 0);
    add(4'h4, 4'h0, 0, 0, 1, 2, 4'h4, 0);
    add(4'h4, 4'h4, 0, 0, 1, 2, 4'h4, 1);
    // stall mid-packet with owner dropping valid
    add(4'h2, 4'h0, 0, 0, 1, 1, 4'h2, 0);
    add(4'h3, 4'h0, 1, 0, 0, 0, 4'h0, 1);
    add(4'h1, 4'h0, 1, 0, 0, 0, 4'h0, 1);
    add(4'h1, 4'h0, 1, 0, 0, 0, 4'h0, 1);
    add(4'h3, 4'h0, 1, 0, 0, 0, 4'h0, 1);
    add(4'h3, 4'h0, 1, 0, 0, 0, 4'h0, 1);
    add(4'h1, 4'h0, 0, 0, 0, 0, 4'h2, 1);
    add(4'h3, 4'h2, 0, 0, 1, 1, 4'h2, 1);
    // flush during req3 burst
    add(4'h8, 4'h0, 0, 0, 1, 3, 4'h8, 0);
    add(4'h9, 4'h0, 0, 1, 0, 0, 4'h0, 1);
    add(4'h9, 4'h9, 0, 0, 1, 0, 4'h1, 0);
    rst_i = 1;
    flush_i = 0;
    fifo_full_i = 0;
    req_valid_i = '1;
    req_last_i = '1;
    req_data_i = {N{32'hDEADBEEF}};
    model_reset();
    #2;
    chk("rst_push", fifo_push_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_id", fifo_id_o, 0);
    chk("rst_data", fifo_data_o, 0);
    @(negedge clk_i);
    rst_i = 0;
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].f, tbl[i].fl);
      chk($sformatf("vec%0d_push", i), fifo_push_o, tbl[i].push);
      chk($sformatf("vec%0d_ready", i), req_ready_o, tbl[i].rdy);
      chk($sformatf("vec%0d_busy", i), busy_o, tbl[i].busy);
      if (tbl[i].push) chk($sformatf("vec%0d_id", i), fifo_id_o, tbl[i].id);
      advance();
    end
    // asynchronous reset in the middle of a burst
    drive(4'h4, 4'h0, 0, 0);
    chk("ar_first_id", fifo_id_o, 2);
    advance();
    drive(4'hF, 4'h0, 0, 0);
    chk("ar_locked_ready", req_ready_o, 4'h4);
    chk("ar_locked_busy", busy_o, 1);
    #2;
    rst_i = 1;
    #1;
    chk("ar_push", fifo_push_o, 0);
    chk("ar_ready", req_ready_o, 0);
    chk("ar_busy", busy_o, 0);
    chk("ar_id", fifo_id_o, 0);
    chk("ar_data", fifo_data_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    model_reset();
    rst_i = 0;
    drive(4'hF, 4'hF, 0, 0);
    chk("ar_after_id", fifo_id_o, 0);
    chk("ar_after_ready", req_ready_o, 4'h1);
    chk("ar_after_busy", busy_o, 0);
    advance();
    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      drive(N'($urandom), N'($urandom & $urandom), ($urandom % 5) == 0, ($urandom % 40) == 0);
      advance();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares the single push port of one fifo_v3 instance between NUM_REQ valid/ready requesters.
- Once a requester wins, it owns the FIFO until it sends its last beat or reaches MAX_BURST beats. The FIFO never sees interleaved beats inside a burst.
- Each pushed beat carries the id of its requester, so the consumer can demultiplex.
- Sits directly in front of fifo_v3. fifo_full_i comes from the FIFO's full flag, and fifo_push_o/fifo_data_o/fifo_id_o drive its push and data inputs.

Parameters:
- NUM_REQ, 4, number of requesters (>=1, need not be a power of two)
- DATA_WIDTH, 32, beat width
- MAX_BURST, 16, maximum beats per grant before forced release; 0 = unlimited
- IDX_W, derived = (NUM_REQ>1) ? $clog2(NUM_REQ) : 1, requester index width
- CNT_W, derived = $clog2(MAX_BURST+1) (min 1), beat counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- flush_i  in  1  synchronous abort of any grant
- req_valid_i  in  NUM_REQ  per-requester beat valid
- req_data_i  in  NUM_REQ*DATA_WIDTH  beats; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last_i  in  NUM_REQ  final beat of packet
- req_ready_o  out  NUM_REQ  beat accepted this cycle when valid & ready
- fifo_full_i  in  1  FIFO full
- fifo_push_o  out  1  push strobe to FIFO
- fifo_data_o  out  DATA_WIDTH  beat to FIFO
- fifo_id_o  out  IDX_W  requester index of the pushed beat
- busy_o  out  1  a grant is locked

Clock and reset (already decided): one clock, clk_i; reset rst_i is asynchronous and active-high.

Behaviour:

State and reset:
- Registers: state (IDLE, LOCKED), owner_q[IDX_W], rr_ptr_q[IDX_W], beat_cnt_q[CNT_W].
- rst_i asserted gives state=IDLE, owner_q=0, rr_ptr_q=0, beat_cnt_q=0.
- While in reset, all outputs are 0.

Requester selection:
- active index in IDLE: the first i with req_valid_i[i]=1, scanning from rr_ptr_q upward and wrapping at NUM_REQ-1 to 0. This is combinational, so there is no arbitration bubble.
- active index in LOCKED: owner_q. Other requesters are ignored.
- any = (IDLE & |req_valid_i) | LOCKED.

Output equations:
- xfer = any & req_valid_i[active] & ~fifo_full_i & ~flush_i.
- fifo_push_o = xfer.
- fifo_data_o = req_data_i[active].
- fifo_id_o = active.
- req_ready_o[i] = (i==active) & any & ~fifo_full_i & ~flush_i. It is 0 for all other i.
- req_ready_o depends combinationally on fifo_full_i, so there is zero latency from full to backpressure. A push is never issued while fifo_full_i=1.
- busy_o = (state==LOCKED).

Transitions on xfer:
- end_burst = req_last_i[active] | (MAX_BURST!=0 & beat_cnt_q==MAX_BURST-1).
- end_burst=1: state goes to IDLE, beat_cnt_q=0, rr_ptr_q=(active==NUM_REQ-1)?0:active+1.
- end_burst=0: state goes to LOCKED, owner_q=active, beat_cnt_q+1.

LOCKED with owner idle:
- If the owner drops req_valid_i while LOCKED, the state holds. There is no re-arbitration and no timeout.
- Pushes from other requesters are blocked.

Single-beat packets:
- valid & last in IDLE pushes in one cycle and the state stays IDLE.
- rr_ptr_q still advances.

Forced release:
- After MAX_BURST beats without last, the grant is released and the remaining beats of that packet re-arbitrate.
- The consumer relies on fifo_id_o, not contiguity, for beats beyond MAX_BURST.

Stalls:
- fifo_full_i=1 in any state freezes all registers and issues no push.

flush_i:
- Takes priority over everything.
- In the same cycle it forces no push and req_ready_o=0.
- Next state is IDLE, beat_cnt_q=0, rr_ptr_q=0; owner_q holds.

Width handling:
- For NUM_REQ not a power of two, the pointer wraps explicitly at NUM_REQ-1.
- beat_cnt_q never exceeds MAX_BURST-1.
- With NUM_REQ=1, the arbiter degenerates to pass-through with burst counting; fifo_id_o=0.

Assertions:
- fifo_push_o |-> ~fifo_full_i.
- $onehot0(req_ready_o).
- In LOCKED, req_ready_o only at owner_q.

Test Plan:
1. Reset, then requesters 0..3 all valid with single-beat packets (last=1), full=0 -> pushes with fifo_id_o 0,1,2,3,0,... on consecutive cycles, no bubbles.
2. Req1 sends a 3-beat packet while req0 and req2 are valid -> ids 1,1,1 pushed contiguously, then 2, then 3/0 per pointer; busy_o=1 only between beat1 and beat3.
3. MAX_BURST=4, req2 sends a 6-beat packet while req3 is valid -> ids 2,2,2,2,3,...,2,2; beat_cnt wraps to 0 after beat 4.
4. Mid-packet, fifo_full_i=1 for 5 cycles and the owner drops valid for 2 cycles -> no push, all ready=0, state/owner/count unchanged; resumes with the correct next beat.
5. flush_i during a LOCKED burst from req3 -> same-cycle push=0; next cycle IDLE, rr_ptr=0; req0 wins if valid.
6. rst_i asserted asynchronously mid-burst (between clock edges) -> outputs 0 immediately; after release, arbitration starts at requester 0 in IDLE.
